// File: rtl/uart_rx_word_pkg.sv
// Shared constants and state encoding for the word-oriented UART receiver.
package uart_rx_word_pkg;

  localparam int unsigned BYTES_PER_WORD       = 4;
  localparam int unsigned BITS_PER_BYTE        = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, bit-timing FSM, one-cycle byte/frame-error pulses.
module uart_rx_byte
  import uart_rx_word_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rxd,
  output logic [BITS_PER_BYTE-1:0] byte_o,
  output logic                     byte_valid_o,
  output logic                     frame_err_o,
  output logic                     idle_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(BITS_PER_BYTE);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_BYTE - 1);

  state_t                   state_q, state_d;
  logic [CW-1:0]            clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [BITS_PER_BYTE-1:0] shift_q, shift_d;
  logic                     sync1_q, sync2_q, prev_q;
  logic                     byte_valid_q, byte_valid_d;
  logic                     frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
          clk_cnt_d = '0;
        end
      end
      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_cnt_q] = sync2_q;
          if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
          else bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        // Return to IDLE at mid stop bit so a back-to-back start edge is not missed.
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d    = '0;
          state_d      = ST_IDLE;
          byte_valid_d = sync2_q;
          frame_err_d  = !sync2_q;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sync1_q      <= rxd;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;
  assign idle_o       = (state_q == ST_IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// Assembles four received UART bytes into a 32-bit word with valid/ack handshake and inter-byte timeout.
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        data_ack,
  output logic [31:0] data_o,
  output logic        data_valid,
  output logic        frame_err,
  output logic        overrun
);

  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TOW      = $clog2(TO_LIMIT + 1);
  localparam int unsigned LW       = $clog2(BYTES_PER_WORD);
  localparam logic [LW-1:0]  LAST_LANE = LW'(BYTES_PER_WORD - 1);
  localparam logic [TOW-1:0] TO_MAX    = TOW'(TO_LIMIT);

  logic [BITS_PER_BYTE-1:0] rx_byte;
  logic                     rx_valid, rx_ferr, rx_idle;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_ferr),
    .idle_o      (rx_idle)
  );

  logic [BYTES_PER_WORD-1:0][BITS_PER_BYTE-1:0] word_buf_q, word_buf_d;
  logic [LW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [TOW-1:0] to_q, to_d;
  logic [31:0]    data_q, data_d;
  logic           data_valid_q, data_valid_d;
  logic           overrun_q, overrun_d;

  always_comb begin
    word_buf_d   = word_buf_q;
    byte_cnt_d   = byte_cnt_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    overrun_d    = 1'b0;
    to_d         = '0;

    if (data_valid_q && data_ack) data_valid_d = 1'b0;

    if (rx_ferr) begin
      byte_cnt_d = '0;
    end else if (rx_valid) begin
      word_buf_d[byte_cnt_q] = rx_byte;
      if (byte_cnt_q == LAST_LANE) begin
        // Completion overrides a same-cycle ack; only an unacked held word is overrun.
        byte_cnt_d   = '0;
        data_d       = word_buf_d;
        data_valid_d = 1'b1;
        overrun_d    = data_valid_q && !data_ack;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end else if (rx_idle && byte_cnt_q != '0) begin
      if (to_q == TO_MAX) byte_cnt_d = '0;
      else to_d = to_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_buf_q   <= '0;
      byte_cnt_q   <= '0;
      to_q         <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      word_buf_q   <= word_buf_d;
      byte_cnt_q   <= byte_cnt_d;
      to_q         <= to_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_o     = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = rx_ferr;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word with CLKS_PER_BIT=16, TIMEOUT_BITS=20.
module tb_uart_rx_word;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxd = 1'b1;
  logic        data_ack = 1'b0;
  logic [31:0] data_o;
  logic        data_valid, frame_err, overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe_base, ov_base;

  uart_rx_word #(
    .CLKS_PER_BIT(16),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data_ack  (data_ack),
    .data_o    (data_o),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int stop_cycles);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (stop_cycles) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Last byte returns at the stop bit so completion timing can be observed.
  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0],   1'b1, CPB);
    send_byte(w[15:8],  1'b1, CPB);
    send_byte(w[23:16], 1'b1, CPB);
    send_byte(w[31:24], 1'b1, 0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (data_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, (n < 60)}, 32'd1);
  endtask

  task automatic ack_word(input string tag);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check(tag, {31'd0, data_valid}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", data_o, 32'h0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    idle(20);

    // Clean word with ack after 5 valid cycles
    fe_base = fe_cnt; ov_base = ov_cnt;
    send_word(32'h12345678);
    wait_valid("clean_wait");
    check("clean_data", data_o, 32'h12345678);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check("clean_valid_held", {31'd0, data_valid}, 32'd1);
    end
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check("clean_valid_drop", {31'd0, data_valid}, 32'd0);
    check("clean_data_hold", data_o, 32'h12345678);
    check("clean_ferr", fe_cnt - fe_base, 32'd0);
    check("clean_ovr", ov_cnt - ov_base, 32'd0);
    idle(20);

    // Glitch rejection
    fe_base = fe_cnt; ov_base = ov_cnt;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    check("glitch_valid", {31'd0, data_valid}, 32'd0);
    send_word(32'hDEADBEEF);
    wait_valid("glitch_wait");
    check("glitch_data", data_o, 32'hDEADBEEF);
    check("glitch_ferr", fe_cnt - fe_base, 32'd0);
    check("glitch_ovr", ov_cnt - ov_base, 32'd0);
    ack_word("glitch_ack");
    idle(20);

    // Framing error drops the partial word
    fe_base = fe_cnt; ov_base = ov_cnt;
    send_byte(8'hAA, 1'b0, CPB);
    idle(32);
    check("ferr_valid", {31'd0, data_valid}, 32'd0);
    send_word(32'h44332211);
    wait_valid("ferr_wait");
    check("ferr_data", data_o, 32'h44332211);
    check("ferr_pulses", fe_cnt - fe_base, 32'd1);
    check("ferr_ovr", ov_cnt - ov_base, 32'd0);
    ack_word("ferr_ack");
    idle(20);

    // Inter-byte timeout discards 0x01, 0x02
    fe_base = fe_cnt; ov_base = ov_cnt;
    send_byte(8'h01, 1'b1, CPB);
    send_byte(8'h02, 1'b1, CPB);
    idle(400);
    send_word(32'hD0C0B0A0);
    wait_valid("to_wait");
    check("to_data", data_o, 32'hD0C0B0A0);
    check("to_ferr", fe_cnt - fe_base, 32'd0);
    check("to_ovr", ov_cnt - ov_base, 32'd0);
    ack_word("to_ack");
    idle(20);

    // Overrun
    fe_base = fe_cnt; ov_base = ov_cnt;
    send_word(32'h11111111);
    wait_valid("ovr_wait1");
    check("ovr_data1", data_o, 32'h11111111);
    idle(CPB);
    send_word(32'h22222222);
    idle(40);
    check("ovr_data2", data_o, 32'h22222222);
    check("ovr_valid", {31'd0, data_valid}, 32'd1);
    check("ovr_pulses", ov_cnt - ov_base, 32'd1);
    check("ovr_ferr", fe_cnt - fe_base, 32'd0);
    ack_word("ovr_ack");
    idle(20);

    // Reset during bit 3 of the second byte
    check("mrst_pre", data_o, 32'h22222222);
    send_byte(8'h0D, 1'b1, CPB);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rxd = i[0];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_data", data_o, 32'h0);
    check("mrst_valid", {31'd0, data_valid}, 32'd0);
    check("mrst_ferr", {31'd0, frame_err}, 32'd0);
    check("mrst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    idle(40);
    fe_base = fe_cnt; ov_base = ov_cnt;
    send_word(32'hCAFEF00D);
    wait_valid("mrst_wait");
    check("mrst_word", data_o, 32'hCAFEF00D);
    check("mrst_ferr_cnt", fe_cnt - fe_base, 32'd0);
    check("mrst_ovr_cnt", ov_cnt - ov_base, 32'd0);
    ack_word("mrst_ack");
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- UART receiver that consumes the serial line driven by the 32-bit word transmitter.
- Deserialises 8N1 frames (LSB first), assembles four consecutive bytes into one 32-bit word, and presents the word with a valid/ack handshake.
- Sits at the receiving end of the link, upstream of whatever consumes received words (CPU mailbox / RAM writer).
- Runs on the system clock and uses an internal bit-period counter, not a divided clock.

Parameters:
- CLKS_PER_BIT, 5208, system clocks per bit period (50 MHz / 9600 baud); must be >= 4.
- TIMEOUT_BITS, 20, idle bit periods after which a partially assembled word is discarded.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- rxd  input  1  asynchronous serial input; idle high.
- data_ack  input  1  consumer accepts data_o; sampled only while data_valid=1.
- data_o  output  32  assembled word; first received byte in [7:0], fourth in [31:24].
- data_valid  output  1  high while an unaccepted word is held in data_o.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a new word completes while data_valid=1.

Behaviour:
- Reset (rst=0 at posedge clk): data_o=0, data_valid=0, frame_err=0, overrun=0.
  - FSM goes to IDLE; byte counter and bit counter are 0; shift register is 0.
  - Synchroniser flops are set to 1 (idle line).
  - Reset mid-frame or mid-word discards all partial state.
- Synchroniser: rxd passes through 2 flops to give rxd_s. All decisions use rxd_s, so there is 2 cycles of input latency.
- FSM states:
  - IDLE: a falling edge on rxd_s (previous 1, current 0) loads bit_cnt=0 and clk_cnt=0, then -> START.
  - START: wait CLKS_PER_BIT/2 clocks (integer division).
    - rxd_s still 0 -> DATA, clk_cnt=0.
    - rxd_s is 1 -> IDLE (glitch rejected, no error pulse).
  - DATA: each time clk_cnt reaches CLKS_PER_BIT-1, sample rxd_s into shift[bit_cnt] (LSB first) and clear clk_cnt.
    - After bit 7 is sampled -> STOP.
  - STOP: when clk_cnt reaches CLKS_PER_BIT-1, sample rxd_s (mid stop bit), then -> IDLE in the same cycle. This allows back-to-back frames.
    - Stop bit = 1: the byte is written into word_buf lane byte_cnt, and byte_cnt increments. On byte_cnt==3 the word completes (below) and byte_cnt wraps to 0.
    - Stop bit = 0: frame_err pulses 1 cycle, byte_cnt clears to 0, and the partial word is dropped. data_o and data_valid are unaffected.
- Word completion, in the cycle after the 4th good stop sample:
  - data_o <= full word and data_valid <= 1.
  - If data_valid was already 1 and no ack arrived that same cycle, overrun pulses 1 cycle. The new word overwrites data_o.
- Handshake:
  - data_valid=1 and data_ack=1 clears data_valid next cycle; data_o holds its value.
  - Ack and completion in the same cycle: completion wins, data_valid stays 1, no overrun.
  - data_ack while data_valid=0 is ignored.
- Inter-byte timeout:
  - While in IDLE with byte_cnt!=0, a timeout counter increments each clock.
  - When it reaches TIMEOUT_BITS*CLKS_PER_BIT, byte_cnt clears to 0 with no error pulse.
  - The counter clears on leaving IDLE and whenever byte_cnt==0.
- Widths:
  - clk_cnt is $clog2(CLKS_PER_BIT) bits.
  - The timeout counter is $clog2(TIMEOUT_BITS*CLKS_PER_BIT+1) bits.
  - No counter may wrap silently.

Decomposition:
- Shared package holds:
  - the state encoding typedef (IDLE, START, DATA, STOP);
  - the constants BYTES_PER_WORD=4, BITS_PER_BYTE=8, DEFAULT_CLKS_PER_BIT=5208.
- One natural sub-module, uart_rx_byte, owns the synchroniser, FSM and byte output (byte, byte_valid, frame_err).
- uart_rx_word wraps uart_rx_byte and adds word assembly, timeout and the handshake.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_BITS=20):
- Clean word: bytes 0x78, 0x56, 0x34, 0x12 sent back-to-back, then data_ack after 5 cycles.
  - Required: data_o=0x12345678, data_valid=1 for exactly 5 cycles, then 0; frame_err=overrun=0.
- Glitch: rxd low for 4 clocks, then high.
  - Required: no state change and no pulses.
  - A following 4-byte word 0xDEADBEEF (bytes EF, BE, AD, DE) is received correctly.
- Framing error: byte 0xAA sent with its stop bit driven 0, then bytes 11, 22, 33, 44.
  - Required: one frame_err pulse.
  - data_o=0x44332211: the partial byte was dropped, and the next word starts at lane 0.
- Timeout: bytes 0x01, 0x02, then idle for 400 clocks, then 0xA0, 0xB0, 0xC0, 0xD0.
  - Required: no pulses; data_o=0xD0C0B0A0.
- Overrun: word 0x11111111 left unacked, then word 0x22222222 received.
  - Required: one overrun pulse; data_o=0x22222222; data_valid stays 1.
- Reset mid-frame: rst=0 for 1 cycle during bit 3 of the second byte, then a full word 0xCAFEF00D.
  - Required: outputs return to 0 during reset; the subsequent word is received exactly.
